wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: writeback queue entries; power of two, at least 2.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port mem_valid, input, 1 bit: memory-stage writeback request.
REQ-005 SHALL have port mem_ready, output, 1 bit: memory-stage request accepted this cycle when high together with mem_valid.
REQ-006 SHALL have ports mem_wsel (input, 5 bits) and mem_wdat (input, 32 bits, word_t): memory-stage destination register and data.
REQ-007 SHALL have ports ex_valid (input, 1), ex_ready (output, 1), ex_wsel (input, 5), ex_wdat (input, 32): execute-stage writeback request, same semantics as the memory-stage ports.
REQ-008 SHALL have ports rf_WEN (output, 1), rf_wsel (output, 5), rf_wdat (output, 32): drives the register file write port.
REQ-009 SHALL have ports rsel1 and rsel2 (input, 5 each): operand lookup selects.
REQ-010 SHALL have ports hit1 and hit2 (output, 1 each) and fwd1 and fwd2 (output, 32 each): pending-write match flags and forwarded data.
REQ-011 SHALL have port empty, output, 1 bit: high when no entry is queued.

Function
REQ-012 SHALL hold an in-order FIFO of {wsel, wdat}; count ranges 0..DEPTH; pointers wrap modulo DEPTH.
REQ-013 SHALL compute free = DEPTH - count, excluding any same-cycle pop.
REQ-014 SHALL drive mem_ready = (free >= 1).
REQ-015 SHALL drive ex_ready = (free >= 2) or (free == 1 and not mem_valid); mem has priority because it is the older instruction.
REQ-016 SHALL, when both sources are accepted in the same cycle, enqueue the mem entry ahead of the ex entry.
REQ-017 SHALL complete the handshake for an accepted request with wsel == 0 but not enqueue it.
REQ-018 SHALL pop the head entry every cycle in which count > 0, driving rf_WEN=1 and rf_wsel/rf_wdat = head for that cycle.
REQ-019 SHALL drive rf_WEN=0, rf_wsel=0 and rf_wdat=0 when count == 0.
REQ-020 SHALL have a latency of one cycle: a request accepted at edge N appears on the rf port during cycle N+1 at the earliest.
REQ-021 SHALL allow a simultaneous pop and up to two pushes in one cycle: count_next = count + pushes - pop, never exceeding DEPTH.
REQ-022 SHALL assert hitK when any queued entry, including the head being popped this cycle, has wsel == rselK and rselK != 0.
REQ-023 SHALL drive fwdK with the data of the youngest matching entry when hitK is asserted, and 0 otherwise.
REQ-024 SHALL exclude same-cycle incoming requests from the lookup.
REQ-025 SHALL drive empty = (count == 0).
REQ-026 SHALL ignore request inputs while the corresponding valid is low.

Reset
REQ-027 SHALL, while nRST is low, clear count and both pointers and zero all entries.
REQ-028 SHALL, while nRST is low, drive outputs to: rf_WEN=0, rf_wsel=0, rf_wdat=0, hit1=hit2=0, fwd1=fwd2=0, empty=1, mem_ready=1, ex_ready=1.
REQ-029 SHALL discard queued entries if reset is asserted mid-drain, with no further rf_WEN pulses after reset.

Structure
REQ-030 SHALL take word_t and regbits_t (5 bits) from cpu_types_pkg, and SHALL add the wb_entry_t struct {regbits_t wsel; word_t wdat;} to cpu_types_pkg.
REQ-031 SHALL place the youngest-match priority search in one sub-module, wb_fwd_lookup, instantiated once per read port.

Verification
REQ-032 SHALL cover: mem_valid with wsel=5, wdat=0xDEADBEEF at edge 0 -> cycle 1: rf_WEN=1, rf_wsel=5, rf_wdat=0xDEADBEEF; cycle 2: empty=1.
REQ-033 SHALL cover: mem and ex both valid in one cycle (wsel 3/0x11, wsel 4/0x22) -> rf writes reg 3, then reg 4, on consecutive cycles.
REQ-034 SHALL cover: two entries with wsel=7 (0xA then 0xB) queued, rsel1=7 -> hit1=1, fwd1=0xB; after the first pop still 0xB; after the second pop hit1=0.
REQ-035 SHALL cover: count=DEPTH-1 with both valid -> mem_ready=1, ex_ready=0, ex entry accepted the following cycle, order preserved.
REQ-036 SHALL cover: ex request with wsel=0 -> ex_ready=1, never appears on the rf port; rsel1=0 -> hit1=0.
REQ-037 SHALL cover: nRST pulled low with 3 entries queued -> immediately empty=1 and rf_WEN=0; no writes after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, register selector and writeback entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   // Register 0 is hardwired zero; writes to it are dropped and it never forwards.
   localparam regbits_t REG_ZERO = 5'd0;

   typedef struct packed {
      regbits_t wsel;
      word_t    wdat;
   } wb_entry_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Youngest-match search over the queued writebacks for one operand read port.
// Latency: combinational.
// Backpressure: none; pure lookup.
// Ports: ents/vld  - queue contents in age order, index 0 = oldest (head)
//        rsel      - operand register select
//        hit/fwd   - match flag and data of the youngest matching entry (0 if none)
module wb_fwd_lookup
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wb_entry_t [DEPTH-1:0] ents,
   input  logic      [DEPTH-1:0] vld,
   input  regbits_t              rsel,
   output logic                  hit,
   output word_t                 fwd
);

   // Scanning oldest to youngest and letting later matches overwrite
   // earlier ones leaves the youngest match in fwd.
   always_comb begin
      hit = 1'b0;
      fwd = '0;
      if (rsel != REG_ZERO) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (ents[i].wsel == rsel)) begin
               hit = 1'b1;
               fwd = ents[i].wdat;
            end
         end
      end
   end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue merging mem- and ex-stage results into one register-file write port, with operand forwarding.
// Latency: one cycle from accepted request to rf write; head drains one entry per cycle.
// Backpressure: mem_ready while any slot is free; ex_ready needs two free slots, or one when mem is idle.
// Ports: mem_* / ex_*  - valid/ready writeback requests (mem is older, takes priority)
//        rf_*          - register-file write port, driven from the queue head
//        rsel*/hit*/fwd* - operand lookup against pending writes
//        empty         - no entries queued
module wb_queue
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     CLK,
   input  logic     nRST,
   input  logic     mem_valid,
   output logic     mem_ready,
   input  regbits_t mem_wsel,
   input  word_t    mem_wdat,
   input  logic     ex_valid,
   output logic     ex_ready,
   input  regbits_t ex_wsel,
   input  word_t    ex_wdat,
   output logic     rf_WEN,
   output regbits_t rf_wsel,
   output word_t    rf_wdat,
   input  regbits_t rsel1,
   input  regbits_t rsel2,
   output logic     hit1,
   output logic     hit2,
   output word_t    fwd1,
   output word_t    fwd2,
   output logic     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t [DEPTH-1:0] entries_q, entries_d;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic [CNT_W-1:0]      free;
   logic                  pop;
   logic                  mem_push;
   logic                  ex_push;
   logic [PTR_W-1:0]      wr_ptr;

   wb_entry_t [DEPTH-1:0] ord_ents;
   logic      [DEPTH-1:0] ord_vld;

   // Readiness ignores the same-cycle pop so ready never depends on the drain path.
   assign free      = CNT_W'(DEPTH) - count_q;
   assign mem_ready = (free != '0);
   assign ex_ready  = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !mem_valid);

   // Accepted requests to r0 complete the handshake but are dropped.
   assign mem_push  = mem_valid && mem_ready && (mem_wsel != REG_ZERO);
   assign ex_push   = ex_valid  && ex_ready  && (ex_wsel  != REG_ZERO);
   assign pop       = (count_q != '0);
   assign empty     = (count_q == '0);

   assign rf_WEN    = pop;
   assign rf_wsel   = pop ? entries_q[head_q].wsel : REG_ZERO;
   assign rf_wdat   = pop ? entries_q[head_q].wdat : '0;

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      wr_ptr    = tail_q;
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      // mem is the older instruction, so it lands ahead of ex.
      if (mem_push) begin
         entries_d[wr_ptr] = '{wsel: mem_wsel, wdat: mem_wdat};
         wr_ptr            = wr_ptr + PTR_W'(1);
      end
      if (ex_push) begin
         entries_d[wr_ptr] = '{wsel: ex_wsel, wdat: ex_wdat};
         wr_ptr            = wr_ptr + PTR_W'(1);
      end
      tail_d  = wr_ptr;
      count_d = count_q + CNT_W'(mem_push) + CNT_W'(ex_push) - CNT_W'(pop);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         entries_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   // Age-ordered view for the lookups; the head being popped this cycle
   // is still valid so a reader racing the rf write still sees it.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ord_ents[i] = entries_q[head_q + PTR_W'(i)];
         ord_vld[i]  = (CNT_W'(i) < count_q);
      end
   end

   wb_fwd_lookup #(.DEPTH(DEPTH)) u_lookup1 (
      .ents (ord_ents),
      .vld  (ord_vld),
      .rsel (rsel1),
      .hit  (hit1),
      .fwd  (fwd1)
   );

   wb_fwd_lookup #(.DEPTH(DEPTH)) u_lookup2 (
      .ents (ord_ents),
      .vld  (ord_vld),
      .rsel (rsel2),
      .hit  (hit2),
      .fwd  (fwd2)
   );

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus random traffic against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_queue;
   import cpu_types_pkg::*;

   localparam int DEPTH = 4;

   logic     CLK = 1'b0;
   logic     nRST;
   logic     mem_valid, ex_valid;
   logic     mem_ready, ex_ready;
   regbits_t mem_wsel, ex_wsel, rf_wsel, rsel1, rsel2;
   word_t    mem_wdat, ex_wdat, rf_wdat, fwd1, fwd2;
   logic     rf_WEN, hit1, hit2, empty;

   int n_checks = 0;
   int n_errors = 0;

   // Reference: pending writes in program order, front = next rf write.
   wb_entry_t model_q[$];

   wb_queue #(.DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_wsel  (mem_wsel),
      .mem_wdat  (mem_wdat),
      .ex_valid  (ex_valid),
      .ex_ready  (ex_ready),
      .ex_wsel   (ex_wsel),
      .ex_wdat   (ex_wdat),
      .rf_WEN    (rf_WEN),
      .rf_wsel   (rf_wsel),
      .rf_wdat   (rf_wdat),
      .rsel1     (rsel1),
      .rsel2     (rsel2),
      .hit1      (hit1),
      .hit2      (hit2),
      .fwd1      (fwd1),
      .fwd2      (fwd2),
      .empty     (empty)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic exp_mem_ready();
      return (DEPTH - model_q.size()) >= 1;
   endfunction

   function automatic logic exp_ex_ready(input logic mv);
      int f;
      f = DEPTH - model_q.size();
      return (f >= 2) || (f == 1 && !mv);
   endfunction

   task automatic check_lookup(input string tag, input regbits_t r, input logic act_hit, input word_t act_fwd);
      logic  h;
      word_t d;
      h = 1'b0;
      d = '0;
      if (r != 5'd0) begin
         foreach (model_q[i]) begin
            if (model_q[i].wsel == r) begin
               h = 1'b1;
               d = model_q[i].wdat;
            end
         end
      end
      check({tag, "_hit"}, 32'(act_hit), 32'(h));
      check({tag, "_fwd"}, act_fwd, d);
   endtask

   task automatic compare_model();
      logic ne;
      ne = (model_q.size() != 0);
      check("empty",     32'(empty),     32'(!ne));
      check("rf_wen",    32'(rf_WEN),    32'(ne));
      check("rf_wsel",   32'(rf_wsel),   ne ? 32'(model_q[0].wsel) : 32'd0);
      check("rf_wdat",   rf_wdat,        ne ? model_q[0].wdat : 32'd0);
      check("mem_ready", 32'(mem_ready), 32'(exp_mem_ready()));
      check("ex_ready",  32'(ex_ready),  32'(exp_ex_ready(mem_valid)));
      check_lookup("lk1", rsel1, hit1, fwd1);
      check_lookup("lk2", rsel2, hit2, fwd2);
   endtask

   // One clock: drive at negedge, check against model, advance model at posedge,
   // return 1 time unit after the edge with inputs still applied.
   task automatic step(input logic mv, input regbits_t mw, input word_t md,
                       input logic ev, input regbits_t ew, input word_t ed,
                       input regbits_t r1, input regbits_t r2);
      logic acc_m, acc_e;
      @(negedge CLK);
      mem_valid = mv; mem_wsel = mw; mem_wdat = md;
      ex_valid  = ev; ex_wsel  = ew; ex_wdat  = ed;
      rsel1 = r1; rsel2 = r2;
      #1;
      compare_model();
      acc_m = mv && exp_mem_ready();
      acc_e = ev && exp_ex_ready(mv);
      @(posedge CLK);
      if (model_q.size() != 0) void'(model_q.pop_front());
      if (acc_m && mw != 5'd0) model_q.push_back('{wsel: mw, wdat: md});
      if (acc_e && ew != 5'd0) model_q.push_back('{wsel: ew, wdat: ed});
      #1;
   endtask

   task automatic idle(input regbits_t r1);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
   endtask

   initial begin
      nRST = 1'b0;
      mem_valid = 1'b0; mem_wsel = '0; mem_wdat = '0;
      ex_valid  = 1'b0; ex_wsel  = '0; ex_wdat  = '0;
      rsel1 = 5'd1; rsel2 = 5'd2;
      #1;
      check("rst_empty",     32'(empty),     32'd1);
      check("rst_rf_wen",    32'(rf_WEN),    32'd0);
      check("rst_rf_wsel",   32'(rf_wsel),   32'd0);
      check("rst_rf_wdat",   rf_wdat,        32'd0);
      check("rst_hit1",      32'(hit1),      32'd0);
      check("rst_fwd2",      fwd2,           32'd0);
      check("rst_mem_ready", 32'(mem_ready), 32'd1);
      check("rst_ex_ready",  32'(ex_ready),  32'd1);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;

      // Single mem write reaches the rf one cycle later, then queue drains.
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      check("s1_wen",  32'(rf_WEN),  32'd1);
      check("s1_wsel", 32'(rf_wsel), 32'd5);
      check("s1_wdat", rf_wdat,      32'hDEADBEEF);
      idle(5'd0);
      check("s1_empty", 32'(empty), 32'd1);

      // Simultaneous mem+ex: mem first.
      step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd0, 5'd0);
      check("s2_first",  32'(rf_wsel), 32'd3);
      idle(5'd0);
      check("s2_second", 32'(rf_wsel), 32'd4);
      check("s2_wdat",   rf_wdat,      32'h22);
      idle(5'd0);

      // Youngest-match forwarding across pops.
      step(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 5'd7, 5'd0);
      check("s3_hit_a", 32'(hit1), 32'd1);
      check("s3_fwd_a", fwd1,      32'hB);
      idle(5'd7);
      check("s3_hit_b", 32'(hit1), 32'd1);
      check("s3_fwd_b", fwd1,      32'hB);
      idle(5'd7);
      check("s3_hit_c", 32'(hit1), 32'd0);
      check("s3_fwd_c", fwd1,      32'd0);

      // Fill to DEPTH-1, then both valid: only mem accepted.
      step(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102, 5'd0, 5'd0);
      step(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104, 5'd0, 5'd0);
      check("s4_mem_ready", 32'(mem_ready), 32'd1);
      check("s4_ex_ready",  32'(ex_ready),  32'd0);
      step(1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106, 5'd0, 5'd0);
      step(1'b0, 5'd0, 32'd0,   1'b1, 5'd6, 32'h106, 5'd0, 5'd0);
      check("s4_order0", 32'(rf_wsel), 32'd4);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      check("s4_order1", 32'(rf_wsel), 32'd5);
      idle(5'd0);
      check("s4_order2", 32'(rf_wsel), 32'd6);
      check("s4_wdat2",  rf_wdat,      32'h106);
      idle(5'd0);

      // Writes to r0 handshake but never reach the rf; r0 never hits.
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
      check("s5_ex_ready", 32'(ex_ready), 32'd1);
      check("s5_wen",      32'(rf_WEN),   32'd0);
      check("s5_hit1",     32'(hit1),     32'd0);
      idle(5'd0);

      // Reset mid-drain discards entries immediately.
      step(1'b1, 5'd8,  32'h201, 1'b1, 5'd9,  32'h202, 5'd8, 5'd0);
      step(1'b1, 5'd10, 32'h203, 1'b1, 5'd11, 32'h204, 5'd8, 5'd0);
      check("s6_pre_wen", 32'(rf_WEN), 32'd1);
      @(negedge CLK);
      mem_valid = 1'b0; ex_valid = 1'b0;
      nRST = 1'b0;
      #1;
      model_q.delete();
      check("s6_empty",    32'(empty),     32'd1);
      check("s6_wen",      32'(rf_WEN),    32'd0);
      check("s6_hit1",     32'(hit1),      32'd0);
      check("s6_ex_ready", 32'(ex_ready),  32'd1);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      repeat (4) idle(5'd9);

      // Random traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      repeat (DEPTH + 1) idle(5'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
